hb_job_sched: RTL



---
 rtl/hb_job_sched_if.sv | 52 +++++
 rtl/hb_job_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hb_job_sched_if.sv
// Bus bundle between hb_job_sched and its requesters / complex multiply-add lane.
// HB_SCHED_PERF_EN adds the job_cnt/stall_cnt performance counter outputs.
interface hb_job_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [2:0]      sel_b;
  logic [1:0]      addr_rowH;
  logic [1:0]      addr_colB;
  logic            issue_valid;
  logic [DW-1:0]   res_r;
  logic [DW-1:0]   res_i;
  logic [4*DW-1:0] outcol0_r;
  logic [4*DW-1:0] outcol0_i;
  logic [4*DW-1:0] outcol1_r;
  logic [4*DW-1:0] outcol1_i;
  logic            done;
  logic [2:0]      done_id;
  logic            busy;
`ifdef HB_SCHED_PERF_EN
  logic [15:0]     job_cnt;
  logic [15:0]     stall_cnt;

  modport master (
    input  req, res_r, res_i,
    output grant, sel_b, addr_rowH, addr_colB, issue_valid,
    output outcol0_r, outcol0_i, outcol1_r, outcol1_i,
    output done, done_id, busy, job_cnt, stall_cnt
  );
  modport slave (
    output req, res_r, res_i,
    input  grant, sel_b, addr_rowH, addr_colB, issue_valid,
    input  outcol0_r, outcol0_i, outcol1_r, outcol1_i,
    input  done, done_id, busy, job_cnt, stall_cnt
  );
`else
  modport master (
    input  req, res_r, res_i,
    output grant, sel_b, addr_rowH, addr_colB, issue_valid,
    output outcol0_r, outcol0_i, outcol1_r, outcol1_i,
    output done, done_id, busy
  );
  modport slave (
    output req, res_r, res_i,
    input  grant, sel_b, addr_rowH, addr_colB, issue_valid,
    input  outcol0_r, outcol0_i, outcol1_r, outcol1_i,
    input  done, done_id, busy
  );
`endif
endinterface

// File: rtl/hb_job_sched.sv
// Round-robin job scheduler for the shared H*B complex product lane; packs 8 results into two columns.
// Optional HB_SCHED_PERF_EN adds job_cnt/stall_cnt counters.
module hb_job_sched #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1,
  parameter int DW      = 16
) (
  input  logic           clk,
  input  logic           rst,
  hb_job_sched_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  // [column][row slot][bits]; slot 3 is the MSB lane, so row r lives in slot 3-r
  typedef logic [1:0][3:0][DW-1:0] buf_t;

  localparam logic [MUL_LAT-1:0] LAST_MASK = MUL_LAT'(1 << (MUL_LAT - 1));

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      sel_b_q, sel_b_d;
  logic [2:0]      k_q, k_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      done_id_q, done_id_d;
  logic [2:0]      win_idx;
  logic            win_found;
  logic            load_out;
  logic            issue_v;
  int              cand;

  logic [MUL_LAT-1:0] vld_sr_q;
  logic [2:0]         k_sr_q [MUL_LAT];
  logic               vld_cap;
  logic [2:0]         k_cap;

  buf_t wb_r_q, wb_i_q, wb_r_d, wb_i_d;
  buf_t oc_r_q, oc_i_q;

  assign issue_v = (state_q == ISSUE);
  assign vld_cap = vld_sr_q[MUL_LAT-1];
  assign k_cap   = k_sr_q[MUL_LAT-1];

  // Circular search for the first requester at or after the pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!win_found && ((bus.req & (NREQ'(1) << cand)) != '0)) begin
        win_found = 1'b1;
        win_idx   = 3'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_b_d   = sel_b_q;
    k_d       = k_q;
    ptr_d     = ptr_q;
    done_id_d = done_id_q;
    load_out  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = NREQ'(1) << win_idx;
          sel_b_d = win_idx;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave once only the final result (captured this cycle) remains in flight
        if ((vld_sr_q & ~LAST_MASK) == '0) begin
          state_d   = DONE;
          grant_d   = '0;
          done_id_d = sel_b_q;
          load_out  = 1'b1;
        end
      end
      DONE: begin
        ptr_d   = 3'((int'(sel_b_q) + 1) % NREQ);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_r_d = wb_r_q;
    wb_i_d = wb_i_q;
    if (vld_cap) begin
      wb_r_d[k_cap[2]][2'd3 - k_cap[1:0]] = bus.res_r;
      wb_i_d[k_cap[2]][2'd3 - k_cap[1:0]] = bus.res_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_b_q   <= '0;
      k_q       <= '0;
      ptr_q     <= '0;
      done_id_q <= '0;
      vld_sr_q  <= '0;
      oc_r_q    <= '0;
      oc_i_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_b_q   <= sel_b_d;
      k_q       <= k_d;
      ptr_q     <= ptr_d;
      done_id_q <= done_id_d;
      vld_sr_q  <= MUL_LAT'({vld_sr_q, issue_v});
      // Folding in the final element keeps the column update atomic
      if (load_out) begin
        oc_r_q <= wb_r_d;
        oc_i_q <= wb_i_d;
      end
    end
  end

  // Datapath tags and working buffer carry no reset; validity comes from vld_sr_q
  always_ff @(posedge clk) begin
    wb_r_q    <= wb_r_d;
    wb_i_q    <= wb_i_d;
    k_sr_q[0] <= k_q;
    for (int i = 1; i < MUL_LAT; i++) k_sr_q[i] <= k_sr_q[i-1];
  end

`ifdef HB_SCHED_PERF_EN
  logic [15:0] job_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      job_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == DONE) job_cnt_q <= job_cnt_q + 16'd1;
      if ((bus.req != '0) && (state_q != IDLE) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.job_cnt   = job_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

  assign bus.grant       = grant_q;
  assign bus.sel_b       = sel_b_q;
  assign bus.addr_rowH   = k_q[1:0];
  assign bus.addr_colB   = {1'b0, k_q[2]};
  assign bus.issue_valid = issue_v;
  assign bus.outcol0_r   = oc_r_q[0];
  assign bus.outcol0_i   = oc_i_q[0];
  assign bus.outcol1_r   = oc_r_q[1];
  assign bus.outcol1_i   = oc_i_q[1];
  assign bus.done        = (state_q == DONE);
  assign bus.done_id     = done_id_q;
  assign bus.busy        = (state_q != IDLE);
endmodule
